// File: rtl/toy_trace_monitor.sv
// Run monitor for the TOY core: logs {pc,a,t} on PC change, counts cycles and detects halt.
// Optional macro TRACE_WRAP_EN: overwrite the oldest entry when full instead of dropping new ones.
module toy_trace_monitor #(
  parameter int unsigned PC_W        = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]          reg_a_in,
  input  logic [DATA_W-1:0]          reg_t_in,
  input  logic                       rd_en,
  output logic [PC_W+2*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       halted,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = PC_W + 2 * DATA_W;
  localparam int unsigned STK_W = $clog2(HALT_CYCLES);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [STK_W-1:0] STK_PRE  = STK_W'(HALT_CYCLES - 2);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PC_W-1:0]  last_pc;
  logic             first_flag;
  logic [STK_W-1:0] stuck;

  logic capture;
  logic do_pop;
  logic do_write;
  logic evict;
  logic lost;
  logic same_pc;

  always_comb begin
    full     = (count == CNT_FULL);
    empty    = (count == '0);
    capture  = ~clear & enable & ~halted & (first_flag | (pc_in != last_pc));
    same_pc  = ~clear & enable & ~halted & ~first_flag & (pc_in == last_pc);
    do_pop   = ~clear & rd_en & ~empty;
    lost     = capture & full & ~do_pop;
`ifdef TRACE_WRAP_EN
    do_write = capture;
    evict    = lost;
`else
    do_write = capture & (~full | do_pop);
    evict    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {pc_in, reg_a_in, reg_t_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
      last_pc     <= '0;
      first_flag  <= 1'b1;
      stuck       <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
      first_flag  <= 1'b1;
      stuck       <= '0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr];
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      // an overwrite retires the oldest entry, so the read side advances with it
      if (do_pop | evict) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_write & ~do_pop & ~evict) count <= count + (PTR_W + 1)'(1);
      else if (do_pop & ~do_write) count <= count - (PTR_W + 1)'(1);
      if (lost) overflow <= 1'b1;
      if (enable) last_pc <= pc_in;
      if (capture) begin
        first_flag <= 1'b0;
        stuck      <= '0;
      end else if (same_pc) begin
        stuck <= stuck + STK_W'(1);
        if (stuck == STK_PRE) halted <= 1'b1;
      end
      if (enable & ~halted & ~(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_toy_trace_monitor.sv
// Randomized and directed bench for toy_trace_monitor against a queue-based reference model.
module tb_toy_trace_monitor;
  localparam int PC_W = 12, DATA_W = 16, DEPTH = 16, HALT_CYCLES = 4, CNT_W = 32;
  localparam int EW = PC_W + 2 * DATA_W;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [PC_W-1:0]   pc_in = '0;
  logic [DATA_W-1:0] reg_a_in = '0, reg_t_in = '0;
  logic [EW-1:0]     rd_data;
  logic              rd_valid, empty, full, overflow, halted;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]  cycle_count;

  toy_trace_monitor #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .HALT_CYCLES(HALT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pc_in(pc_in),
    .reg_a_in(reg_a_in), .reg_t_in(reg_t_in), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .halted(halted), .cycle_count(cycle_count));

  always #5 clk = ~clk;

  logic [EW-1:0]    m_q[$];
  bit               m_first, m_halted, m_ovf, m_valid;
  logic [PC_W-1:0]  m_last;
  int               m_stuck;
  logic [EW-1:0]    m_data;
  logic [CNT_W-1:0] m_cyc;
  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_first = 1; m_halted = 0; m_ovf = 0; m_valid = 0;
    m_last = '0; m_stuck = 0; m_data = '0; m_cyc = '0;
  endtask

  task automatic model_clock();
    if (clear) begin
      m_q.delete();
      m_ovf = 0; m_halted = 0; m_cyc = '0; m_first = 1; m_stuck = 0; m_valid = 0;
    end else begin
      bit cap, pop, was_halted;
      int n;
      n = m_q.size();
      was_halted = m_halted;
      cap = enable && !m_halted && (m_first || pc_in != m_last);
      pop = rd_en && n > 0;
      m_valid = pop;
      if (pop) m_data = m_q.pop_front();
      if (cap) begin
        if (n == DEPTH && !pop) begin
          m_ovf = 1;
`ifdef TRACE_WRAP_EN
          void'(m_q.pop_front());
          m_q.push_back({pc_in, reg_a_in, reg_t_in});
`endif
        end else begin
          m_q.push_back({pc_in, reg_a_in, reg_t_in});
        end
      end
      if (enable && !was_halted) begin
        if (cap) m_stuck = 0;
        else begin
          m_stuck++;
          if (m_stuck >= HALT_CYCLES - 1) m_halted = 1;
        end
        if (m_cyc != '1) m_cyc = m_cyc + 1;
      end
      if (enable) begin
        m_last = pc_in;
        if (cap) m_first = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " rd_valid"}, 64'(rd_valid), 64'(m_valid));
    check({tag, " rd_data"}, 64'(rd_data), 64'(m_data));
    check({tag, " count"}, 64'(count), 64'(m_q.size()));
    check({tag, " empty"}, 64'(empty), 64'(m_q.size() == 0));
    check({tag, " full"}, 64'(full), 64'(m_q.size() == DEPTH));
    check({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, " halted"}, 64'(halted), 64'(m_halted));
    check({tag, " cycle_count"}, 64'(cycle_count), 64'(m_cyc));
  endtask

  task automatic step(input bit e, input bit c, input bit r, input logic [PC_W-1:0] pc,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] t, input string tag);
    enable = e; clear = c; rd_en = r; pc_in = pc; reg_a_in = a; reg_t_in = t;
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  // asserted away from the clock edge; outputs must drop without waiting for a clock
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [PC_W-1:0] pc_r;
    pc_r = '0;
    #1;
    do_reset("por");

    for (int i = 0; i < 3; i++)
      step(1, 0, 0, PC_W'(12'h010 + i), DATA_W'(i + 1), 16'hFFFF, "tp1_cap");
    check("tp1_count3", 64'(count), 64'd3);
    step(0, 0, 1, '0, '0, '0, "tp1_pop");
    check("tp1_pop0", 64'(rd_data), 64'h010_0001_FFFF);
    step(0, 0, 0, '0, '0, '0, "tp1_gap");
    step(0, 0, 1, '0, '0, '0, "tp1_pop");
    check("tp1_pop1", 64'(rd_data), 64'h011_0002_FFFF);
    step(0, 0, 1, '0, '0, '0, "tp1_pop");
    check("tp1_pop2", 64'(rd_data), 64'h012_0003_FFFF);
    check("tp1_empty", 64'(empty), 64'd1);

    step(1, 1, 0, 12'h020, '0, '0, "tp2_clr");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 12'h020, 16'h1234, 16'h5678, "tp2_hold");
    check("tp2_halted", 64'(halted), 64'd1);
    check("tp2_cyc", 64'(cycle_count), 64'd4);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 12'h021, '0, '0, "tp2_after");
    check("tp2_count", 64'(count), 64'd1);
    check("tp2_cyc_frozen", 64'(cycle_count), 64'd4);

    step(1, 1, 0, '0, '0, '0, "tp3_clr");
    for (int i = 0; i < 20; i++)
      step(1, 0, 0, PC_W'(i), DATA_W'($urandom), DATA_W'($urandom), "tp3_fill");
    check("tp3_full", 64'(full), 64'd1);
    check("tp3_ovf", 64'(overflow), 64'd1);
    step(0, 0, 1, '0, '0, '0, "tp3_drain");
`ifdef TRACE_WRAP_EN
    check("tp3_oldest", 64'(rd_data[EW-1 -: PC_W]), 64'h004);
`else
    check("tp3_oldest", 64'(rd_data[EW-1 -: PC_W]), 64'h000);
`endif
    for (int i = 0; i < 15; i++) step(0, 0, 1, '0, '0, '0, "tp3_drain");

    step(1, 1, 0, '0, '0, '0, "tp4_clr");
    for (int i = 0; i < 16; i++) step(1, 0, 0, PC_W'(12'h100 + i), '0, DATA_W'(i), "tp4_fill");
    step(1, 0, 1, 12'h200, 16'hABCD, 16'h0001, "tp4_both");
    check("tp4_count", 64'(count), 64'd16);
    check("tp4_ovf", 64'(overflow), 64'd0);
    check("tp4_oldest", 64'(rd_data[EW-1 -: PC_W]), 64'h100);
    for (int i = 0; i < 16; i++) step(0, 0, 1, '0, '0, '0, "tp4_drain");
    check("tp4_newest", 64'(rd_data), 64'h200_ABCD_0001);

    step(0, 1, 0, '0, '0, '0, "tp5_clr");
    step(0, 0, 1, '0, '0, '0, "tp5_rd_empty");
    check("tp5_rv", 64'(rd_valid), 64'd0);
    check("tp5_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, PC_W'(12'h040 + i), '0, '0, "tp5_cap");
    step(1, 1, 1, 12'h050, '0, '0, "tp5_clr_busy");
    check("tp5_clr_cnt", 64'(count), 64'd0);
    check("tp5_clr_rv", 64'(rd_valid), 64'd0);
    check("tp5_clr_cyc", 64'(cycle_count), 64'd0);

    step(1, 1, 0, '0, '0, '0, "tp6_clr");
    for (int i = 0; i < 5; i++) step(1, 0, 0, PC_W'(12'h300 + i), '0, '0, "tp6_cap");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 12'h304, '0, '0, "tp6_hold");
    check("tp6_cnt5", 64'(count), 64'd5);
    check("tp6_halted", 64'(halted), 64'd1);
    do_reset("tp6_rst");
    step(1, 0, 0, 12'h304, 16'h0BEE, '0, "tp6_first");
    check("tp6_first_cap", 64'(count), 64'd1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) != 0) pc_r = PC_W'($urandom_range(15));
      if ($urandom_range(599) == 0) do_reset("rnd_rst");
      step($urandom_range(7) != 0, $urandom_range(49) == 0, $urandom_range(2) == 0,
           pc_r, DATA_W'($urandom), DATA_W'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/toy_trace_monitor.md
Name: toy_trace_monitor

Overview:
- Synthesizable run monitor for the TOY processor core; successor to the bench-only watching of PC/A/T outputs.
- Samples the core's program counter and A/T registers each cycle, logs a snapshot into a circular trace buffer whenever PC changes, counts executed cycles and detects halt (PC stuck).
- Sits beside the core in simulation and on-board debug builds; the trace is drained by a host or bench over a simple read port.

Parameters:
- PC_W, 12, program counter width.
- DATA_W, 16, width of register A and register T.
- DEPTH, 16, trace entries; power of two, at least 2.
- HALT_CYCLES, 4, consecutive enabled cycles with unchanged PC that declare halt; at least 2.
- CNT_W, 32, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  monitor active; when low, nothing is sampled or counted.
- clear  in  1  synchronous clear of buffer, flags and counters.
- pc_in  in  PC_W  core program counter.
- reg_a_in  in  DATA_W  core register A.
- reg_t_in  in  DATA_W  core register T.
- rd_en  in  1  pop one trace entry.
- rd_data  out  PC_W+2*DATA_W  entry read; {pc, a, t}, pc in the MSBs.
- rd_valid  out  1  rd_data valid this cycle.
- count  out  clog2(DEPTH)+1  entries held.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a capture was lost or overwritten.
- halted  out  1  sticky halt flag.
- cycle_count  out  CNT_W  enabled, non-halted cycles.

Behaviour:
- Reset (reset low, async): all outputs 0, empty=1. Pointers, last_pc and the stuck counter are 0. The first_flag is set.
- Capture condition: enable & ~halted & (first_flag | pc_in!=last_pc).
  - On capture, {pc_in,reg_a_in,reg_t_in} is written at the write pointer.
  - last_pc<=pc_in and first_flag<=0.
- last_pc updates on every enabled cycle.
- Full, capture, no pop: the entry is dropped and overflow<=1.
- Full, capture, with pop in the same cycle: both the write and the read happen; count stays DEPTH; overflow unchanged.
- Read:
  - rd_en with count>0 makes rd_data and rd_valid registered one cycle later (latency 1).
  - rd_valid is a single-cycle pulse.
  - rd_en while empty is ignored; rd_valid=0 and rd_data holds its last value.
- Simultaneous write and read with count>0: count unchanged.
- Empty with capture and rd_en in the same cycle: the write is accepted and the read is ignored; there is no bypass.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Halt detection:
  - stuck counter increments on enabled cycles with pc_in==last_pc and first_flag=0; it resets to 0 on a PC change.
  - halted<=1 when the counter reaches HALT_CYCLES-1 during such a cycle, i.e. after HALT_CYCLES equal consecutive samples including the first.
  - halted is sticky until clear or reset; captures stop while halted.
- cycle_count increments on enable & ~halted cycles and saturates at all-ones.
- Reads remain permitted while halted.
- clear (sync, when enable is don't-care):
  - empties the buffer and zeroes the counters, overflow and halted;
  - sets first_flag;
  - suppresses any capture and read in that cycle; rd_valid=0 next cycle.
- reset asserted mid-operation: immediate return to the reset state; the buffer contents are don't-care.

Optional Feature:
- Macro TRACE_WRAP_EN.
- Defined: when a capture arrives while full without a pop, the oldest entry is overwritten. The read pointer advances, count stays DEPTH and overflow<=1, so the trace keeps the most recent DEPTH PCs.
- Undefined: drop-new behaviour as in Behaviour.

Test Plan:
- Reset then enable, pc_in sequence 0x010,0x011,0x012 with A=0x0001..0x0003, T=0xFFFF -> count=3; three pops return 0x010_0001_FFFF, 0x011_0002_FFFF, 0x012_0003_FFFF, each with rd_valid one cycle after rd_en; empty=1 at the end.
- pc_in held at 0x020 for 4 enabled cycles (HALT_CYCLES=4) -> one entry captured; halted=1 after the 4th cycle; cycle_count frozen at 4; a later pc_in 0x021 is not captured.
- 20 distinct PCs 0x000..0x013 without reads (DEPTH=16):
  - without the macro -> full=1, overflow=1, entries 0x000..0x00F;
  - with TRACE_WRAP_EN -> entries 0x004..0x013.
- At full, a new PC and rd_en in the same cycle -> count stays 16, overflow=0, the popped entry is the oldest, the new PC is stored.
- rd_en on empty -> rd_valid=0, count=0. clear asserted with rd_en and a new PC -> next cycle count=0, rd_valid=0, halted=0, cycle_count=0.
- reset pulsed low mid-trace (count=5, halted=1) -> all outputs 0 and empty=1 asynchronously; the first enabled sample afterwards is captured.
